// File: rtl/mul64_seq.sv
// rtl/mul64_seq.sv - sequential shift-and-add 64x64 unsigned multiplier (low 64 bits, zero/overflow flags)

module add64 (
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  output logic [63:0] sum_o,
  output logic        cout_o,
  output logic        ovf_o,
  output logic        zero_o
);
  logic carry;
  logic carry_msb;

  always_comb begin
    sum_o     = '0;
    carry     = 1'b0;
    carry_msb = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i == 63) carry_msb = carry;
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
    ovf_o  = carry ^ carry_msb;
    zero_o = (sum_o == 64'd0);
  end
endmodule

module mul64_seq #(
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] in1,
  input  logic [63:0] in2,
  output logic [63:0] out,
  output logic        busy,
  output logic        done,
  output logic        z_mul_flag,
  output logic        o_mul_flag
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q;
  logic [63:0] acc_q, mcand_q, mplier_q, out_q;
  logic [5:0]  cnt_q;
  logic        lost_q, ovf_q, busy_q, done_q, z_q, o_q;

  logic [63:0] acc_d, mcand_d, mplier_d;
  logic [5:0]  cnt_d;
  logic        lost_d, ovf_d, last_d;

  logic [63:0] add_sum;
  logic        add_cout;
  logic        unused_add_ovf, unused_add_zero;

  add64 u_add (
    .a_i    (acc_q),
    .b_i    (mcand_q),
    .sum_o  (add_sum),
    .cout_o (add_cout),
    .ovf_o  (unused_add_ovf),
    .zero_o (unused_add_zero)
  );

  // Overflow needs both a carry/lost bit and an actual addition in this step.
  always_comb begin
    acc_d    = mplier_q[0] ? add_sum : acc_q;
    ovf_d    = ovf_q | (mplier_q[0] & (add_cout | lost_q));
    mcand_d  = {mcand_q[62:0], 1'b0};
    lost_d   = lost_q | mcand_q[63];
    mplier_d = {1'b0, mplier_q[63:1]};
    cnt_d    = cnt_q + 6'd1;
    last_d   = (cnt_q == 6'd63) || ((EARLY_EXIT != 0) && (mplier_d == 64'd0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      lost_q   <= 1'b0;
      ovf_q    <= 1'b0;
      out_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      z_q      <= 1'b0;
      o_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q    <= '0;
            mcand_q  <= in1;
            mplier_q <= in2;
            cnt_q    <= '0;
            lost_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          ovf_q    <= ovf_d;
          mcand_q  <= mcand_d;
          lost_q   <= lost_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_d;
          if (last_d) begin
            out_q   <= acc_d;
            z_q     <= (acc_d == 64'd0);
            o_q     <= ovf_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out        = out_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign z_mul_flag = z_q;
  assign o_mul_flag = o_q;
endmodule

// File: tb/tb_mul64_seq.sv
// tb/tb_mul64_seq.sv - directed and random checks of mul64_seq with and without early exit

module tb_mul64_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start0 = 1'b0;
  logic [63:0] in1 = '0;
  logic [63:0] in2 = '0;
  logic [63:0] out1, out0;
  logic        busy1, busy0, done1, done0, z1, z0, o1, o0;
  int          n_total = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  mul64_seq #(.EARLY_EXIT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
    .out(out1), .busy(busy1), .done(done1), .z_mul_flag(z1), .o_mul_flag(o1)
  );

  mul64_seq #(.EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .in1(in1), .in2(in2),
    .out(out0), .busy(busy0), .done(done0), .z_mul_flag(z0), .o_mul_flag(o0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int msb_idx(input logic [63:0] v);
    int k = 0;
    for (int i = 0; i < 64; i++) if (v[i]) k = i;
    return k;
  endfunction

  // Called at a negedge; leaves at the first IDLE cycle so the next call starts back-to-back.
  task automatic run_op(input string tag, input bit ee0, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] eo, input logic ez, input logic eov, input int elat);
    int lat;
    bit seen;
    in1 = a;
    in2 = b;
    if (ee0) start0 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start0 = 1'b0;
    in1 = '1;
    in2 = '1;
    chk({tag, " busy"}, 64'(ee0 ? busy0 : busy1), 64'd1);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      seen = ee0 ? done0 : done1;
    end
    chk({tag, " done"}, 64'(seen), 64'd1);
    chk({tag, " latency"}, 64'(lat), 64'(elat));
    chk({tag, " out"}, ee0 ? out0 : out1, eo);
    chk({tag, " z"}, 64'(ee0 ? z0 : z1), 64'(ez));
    chk({tag, " o"}, 64'(ee0 ? o0 : o1), 64'(eov));
    @(negedge clk);
    chk({tag, " idle"}, 64'({ee0 ? busy0 : busy1, ee0 ? done0 : done1}), 64'd0);
  endtask

  initial begin
    int lat;
    bit seen;
    logic [63:0] a, b, m;
    logic [127:0] prod;

    repeat (2) @(negedge clk);
    chk("rst out", out1, 64'd0);
    chk("rst flags", 64'({busy1, done1, z1, o1}), 64'd0);
    chk("rst0 flags", 64'({busy0, done0, z0, o0}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("3x5", 0, 64'd3, 64'd5, 64'd15, 0, 0, 3);
    run_op("max x1", 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1);
    run_op("max x2", 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 2);
    run_op("2^32 sq", 0, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 1, 1, 33);
    run_op("x0", 0, 64'h1_0000_0000, 64'd0, 64'd0, 1, 0, 1);
    run_op("msb lost", 0, 64'h8000_0000_0000_0001, 64'd2, 64'd2, 0, 1, 2);

    // Start pulses during RUN and in the DONE cycle must both be ignored.
    in1 = 64'd7; in2 = 64'd9; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); in1 = 64'd100; start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 2;
    seen = done1;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      seen = done1;
    end
    chk("7x9 done", 64'(seen), 64'd1);
    chk("7x9 latency", 64'(lat), 64'd4);
    chk("7x9 out", out1, 64'd63);
    in1 = 64'd100; in2 = 64'd9; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start in done ignored", 64'({busy1, done1}), 64'd0);
    run_op("100x9", 0, 64'd100, 64'd9, 64'd900, 0, 0, 4);

    in1 = 64'hFF; in2 = 64'hFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("midrun rst out", out1, 64'd0);
    chk("midrun rst flags", 64'({busy1, done1, z1, o1}), 64'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | done1 | busy1;
    end
    chk("no done after rst", 64'(seen), 64'd0);

    run_op("ee0 6x7", 1, 64'd6, 64'd7, 64'd42, 0, 0, 64);
    run_op("ee0 x0", 1, 64'd5, 64'd0, 64'd0, 1, 0, 64);

    for (int n = 0; n < 2000; n++) begin
      m = ($urandom_range(0, 3) == 0) ? '1 : ((64'd1 << $urandom_range(0, 63)) - 64'd1);
      a = {$urandom, $urandom} & m;
      m = ((64'd1 << $urandom_range(0, 63)) - 64'd1);
      b = {$urandom, $urandom} & m;
      prod = {64'd0, a} * {64'd0, b};
      run_op("rand", 0, a, b, prod[63:0], prod[63:0] == 64'd0, prod[127:64] != 64'd0, msb_idx(b) + 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mul64_seq.md
Name: mul64_seq

Overview:
- Multi-cycle unsigned 64x64 multiplier. Keeps the low 64 bits of the product and sets zero and overflow flags.
- A single 64-bit ripple adder instance (add64) is sequenced by a shift-and-add FSM, one multiplier bit per cycle.
- Sits beside the ALU as the execute-stage handler for multiply operations. Uses a start/busy/done handshake so the pipeline can stall on busy.

Parameters:
EARLY_EXIT, 1, 1 = stop iterating once the remaining multiplier bits are all zero; 0 = always run 64 iterations.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a multiply; sampled only in IDLE
in1  input  64  multiplicand, captured when start is accepted
in2  input  64  multiplier, captured when start is accepted
out  output  64  low 64 bits of in1*in2; held until the next result is written
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse in DONE; out and flags are valid from this cycle on
z_mul_flag  output  1  out == 0
o_mul_flag  output  1  true product >= 2^64 (unsigned overflow)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: on a clk edge with rst=1, state = IDLE and out = 0, busy = 0, done = 0, z_mul_flag = 0, o_mul_flag = 0. All internal registers clear. rst has priority over every other input, including in the middle of RUN; the operation in progress is discarded.
- Internal registers:
  - acc[63:0]: running sum.
  - mcand[63:0]: in1, shifted left by one each iteration.
  - mplier[63:0]: in2, shifted right by one each iteration.
  - cnt[5:0]: iteration count.
  - lost: sticky; set when a 1 has been shifted out of mcand[63].
  - ovf: sticky overflow.
- The add64 instance computes acc + mcand. Its carry-out flag is used for overflow detection; its overflow and zero flags are ignored.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at an edge:
  - acc = 0, mcand = in1, mplier = in2, cnt = 0, lost = 0, ovf = 0; go to RUN.
  - start=0: stay in IDLE.
- RUN, each edge:
  - If mplier[0] = 1: acc = adder sum; ovf is set if the adder carry-out = 1 or lost = 1.
  - Then mcand = mcand << 1 and lost |= old mcand[63]; mplier = mplier >> 1; cnt += 1.
  - Exit to DONE when cnt == 63, or when EARLY_EXIT = 1 and the shifted mplier == 0.
  - On the exit edge, out is loaded with the final acc (including that edge's addition), z_mul_flag = (final acc == 0), o_mul_flag = final ovf.
- DONE: done = 1 and busy = 1 for exactly one cycle, then go to IDLE.
- Latency, with k = index of the most-significant set bit of in2 (k = 0 when in2 = 0):
  - EARLY_EXIT = 1: RUN lasts k+1 cycles.
  - EARLY_EXIT = 0: RUN always lasts 64 cycles.
  - done is high in the cycle after the last RUN cycle. Minimum start-to-done is 2 edges.
- start while busy (RUN or DONE) is ignored; nothing is queued. start in the same cycle done is high is also ignored.
- Back-to-back: start can be accepted in the first IDLE cycle after DONE.
- in1 and in2 may change freely after the start edge; operands are captured internally.
- out and flags hold their values through IDLE and RUN of the next operation until that operation's exit edge overwrites them.
- Overflow rule: overflow is flagged iff the 128-bit product exceeds 2^64-1. Causes:
  - an addition with carry-out, or
  - an addition performed after a 1 has been shifted out of mcand (lost = 1).
  - A 1 shifted out of mcand with no later addition does not flag overflow.

Test Plan:
- in1 = 3, in2 = 5, start 1 cycle -> busy during 3 RUN cycles + DONE; done pulses 4 cycles after the start edge; out = 15, z = 0, o = 0.
- in1 = 0xFFFF_FFFF_FFFF_FFFF, in2 = 1 -> 1 RUN cycle; out = 0xFFFF_FFFF_FFFF_FFFF, o = 0. Repeat with in2 = 2 -> out = 0xFFFF_FFFF_FFFF_FFFE, o = 1.
- in1 = 2^32, in2 = 2^32 -> out = 0, z = 1, o = 1 (lost path). in1 = 0x1_0000_0000, in2 = 0 -> 1 RUN cycle; out = 0, z = 1, o = 0.
- Start 7*9; pulse start again with in1 = 100 during RUN -> second start ignored; out = 63; next start after DONE gives 100*in2 correctly.
- rst = 1 in the 2nd RUN cycle of 0xFF*0xFF -> next edge: IDLE, out = 0, busy = 0, done = 0, flags = 0; no done pulse follows.
- EARLY_EXIT = 0, in1 = 6, in2 = 7 -> exactly 64 RUN cycles; out = 42, done pulse in cycle 65 after the start edge.
- Random: 2000 operand pairs checked against a 128-bit model (low 64 bits, zero flag, overflow = high half nonzero) and the latency formula.
